// File: rtl/dc_acc_fifo.sv
// Synchronous word FIFO between the router and one accelerator, with registered flags and count.
// Define DC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module dc_acc_fifo #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  put_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  get_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
`ifdef DC_FIFO_ERR_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CntFull  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CntAfull = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  put_ok, get_ok, mem_we;

    // Acceptance uses the registered flags, so a put while full is dropped even alongside a get.
    assign put_ok = put_req && !full_q;
    assign get_ok = get_req && !empty_q;
    assign mem_we = put_ok && !flush && !reset;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (put_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (get_ok) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                data_out_d   = mem_q[rd_ptr_q];
                data_valid_d = 1'b1;
            end
            unique case ({put_ok, get_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == CntFull);
        empty_d = (count_d == '0);
        afull_d = (count_d >= CntAfull);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            afull_q      <= afull_d;
        end
    end

    // Storage is not reset; stale words become unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef DC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (put_req & full_q);
        underflow_d = underflow_q | (get_req & empty_q);
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
    assign count       = count_q;

endmodule

// File: tb/tb_dc_acc_fifo.sv
// Directed bench for dc_acc_fifo: reset, ordering, full/empty boundaries, flush and pointer wrap.
module tb_dc_acc_fifo;

    logic        clk = 1'b0;
    logic        reset, flush, put_req, get_req;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_valid, full, empty, almost_full;
    logic [4:0]  count;
`ifdef DC_FIFO_ERR_EN
    logic        overflow, underflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    dc_acc_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .put_req     (put_req),
        .data_in     (data_in),
        .get_req     (get_req),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
`ifdef DC_FIFO_ERR_EN
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs set before the call are sampled at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        put_req = 1'b0;
        get_req = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        int exp_rd;
        reset   = 1'b1;
        data_in = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // 1. reset state after idle
        repeat (3) tick();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_dout", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_afull", almost_full, 0);

        // 2. three words through
        for (int i = 0; i < 3; i++) begin
            put_req = 1'b1;
            data_in = 122 + i;
            tick();
            check("t2_count", count, i + 1);
            check("t2_empty", empty, 0);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            get_req = 1'b1;
            tick();
            check("t2_dout", data_out, 122 + i);
            check("t2_valid", data_valid, 1);
        end
        check("t2_empty_end", empty, 1);
        idle();
        tick();
        check("t2_valid_off", data_valid, 0);
        check("t2_dout_hold", data_out, 124);

        // 3. fill to full, overflow attempt, full put+get, drain
        for (int i = 0; i < 16; i++) begin
            put_req = 1'b1;
            data_in = i;
            tick();
            check("t3_count", count, i + 1);
            check("t3_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
            check("t3_full", full, (i + 1 == 16) ? 1 : 0);
        end
        data_in = 99;
        tick();
        check("t3_drop_count", count, 16);
`ifdef DC_FIFO_ERR_EN
        check("t3_overflow", overflow, 1);
`endif
        get_req = 1'b1;
        tick();
        check("t3_fullpg_count", count, 15);
        check("t3_fullpg_dout", data_out, 0);
        put_req = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("t3_drain", data_out, i);
        end
        check("t3_drained_empty", empty, 1);
        tick();
        check("t3_get_empty_valid", data_valid, 0);
        check("t3_get_empty_dout", data_out, 15);
        // empty with put+get: only the put lands
        put_req = 1'b1;
        data_in = 55;
        tick();
        check("t3_emptypg_count", count, 1);
        check("t3_emptypg_valid", data_valid, 0);
        put_req = 1'b0;
        tick();
        check("t3_emptypg_dout", data_out, 55);
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef DC_FIFO_ERR_EN
        check("t3_ovf_clear", overflow, 0);
`endif

        // 4. count==1 with put+get returns the old word
        put_req = 1'b1;
        data_in = 7;
        tick();
        data_in = 8;
        get_req = 1'b1;
        tick();
        check("t4_dout", data_out, 7);
        check("t4_count", count, 1);
        check("t4_empty", empty, 0);
        put_req = 1'b0;
        tick();
        check("t4_dout2", data_out, 8);
        check("t4_count2", count, 0);
        idle();

        // 5. flush overrides put, then get on empty is ignored
        for (int i = 0; i < 5; i++) begin
            put_req = 1'b1;
            data_in = 1 + i;
            tick();
        end
        check("t5_count5", count, 5);
        flush   = 1'b1;
        data_in = 77;
        tick();
        check("t5_flush_count", count, 0);
        check("t5_flush_empty", empty, 1);
        check("t5_flush_dout", data_out, 8);
        idle();
        get_req = 1'b1;
        tick();
        check("t5_get_valid", data_valid, 0);
        check("t5_get_dout", data_out, 8);
        check("t5_get_count", count, 0);
`ifdef DC_FIFO_ERR_EN
        check("t5_underflow", underflow, 1);
`endif
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef DC_FIFO_ERR_EN
        check("t5_underflow_clr", underflow, 0);
`endif

        // reset mid-operation clears data_out as well
        put_req = 1'b1;
        data_in = 33;
        tick();
        put_req = 1'b0;
        get_req = 1'b1;
        tick();
        check("rst2_pre_dout", data_out, 33);
        get_req = 1'b0;
        put_req = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("rst2_dout", data_out, 0);
        check("rst2_count", count, 0);
        check("rst2_empty", empty, 1);

        // 6. wrap: keep ~3 words in flight over 40 words
        exp_rd = 100;
        for (int i = 0; i < 3; i++) begin
            put_req = 1'b1;
            data_in = 100 + i;
            tick();
        end
        for (int i = 3; i < 40; i++) begin
            put_req = 1'b1;
            get_req = 1'b1;
            data_in = 100 + i;
            tick();
            check("t6_dout", data_out, exp_rd);
            check("t6_count", count, 3);
            exp_rd++;
        end
        put_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_tail", data_out, exp_rd);
            exp_rd++;
        end
        check("t6_empty", empty, 1);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
